// File: rtl/ex_pkg.sv
// Execute-stage shared definitions: ALU opcodes, multiply FSM states,
// control bundle and default widths.
package ex_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int PC_W_DEF   = 64;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_SLT  = 3'd4,
        OP_MUL  = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        MUL2 = 2'd2
    } state_e;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
        logic memread;
        logic branch;
    } ctrl_t;

endpackage

// File: rtl/ex_stage_mult2_if.sv
// ID/EX -> EX -> EX/MEM bundle. master = pipeline side (drives ID/EX
// fields and flush), slave = execute stage (drives EX/MEM fields, stall).
interface ex_stage_mult2_if #(
    parameter int DATA_W = ex_pkg::DATA_W_DEF,
    parameter int PC_W   = ex_pkg::PC_W_DEF
);
    logic [PC_W-1:0]   pc_in;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    logic              alu_src;
    logic [2:0]        alu_op;
    logic [4:0]        rd_in;
    logic              regwrite_in;
    logic              memtoreg_in;
    logic              memwrite_in;
    logic              memread_in;
    logic              branch_in;
    logic              flush;

    logic [PC_W-1:0]   branch_pc;
    logic [DATA_W-1:0] alu_out;
    logic              zero;
    logic [DATA_W-1:0] dreg2;
    logic [4:0]        inst2;
    logic              writeback1;
    logic              writeback2;
    logic              memwrite;
    logic              memread;
    logic              membranch;
    logic              stall;

    modport master (
        output pc_in, rdata1, rdata2, imm, alu_src, alu_op, rd_in,
        output regwrite_in, memtoreg_in, memwrite_in, memread_in,
        output branch_in, flush,
        input  branch_pc, alu_out, zero, dreg2, inst2,
        input  writeback1, writeback2, memwrite, memread, membranch,
        input  stall
    );

    modport slave (
        input  pc_in, rdata1, rdata2, imm, alu_src, alu_op, rd_in,
        input  regwrite_in, memtoreg_in, memwrite_in, memread_in,
        input  branch_in, flush,
        output branch_pc, alu_out, zero, dreg2, inst2,
        output writeback1, writeback2, memwrite, memread, membranch,
        output stall
    );

endinterface

// File: rtl/mult2_core.sv
// Two-step registered multiplier: captures operands on start, forms two
// partial products in the next cycle, sums them while done is high.
// Ports: clk, arst_n, start, clear, a, b -> product, busy, done.
module mult2_core #(
    parameter int DATA_W = ex_pkg::DATA_W_DEF
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic              clear,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] product,
    output logic              busy,
    output logic              done
);

    localparam int H = DATA_W / 2;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] pp_lo;
    logic [H-1:0]      pp_hi;
    logic              mul1_q;
    logic              mul2_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            pp_lo  <= '0;
            pp_hi  <= '0;
            mul1_q <= 1'b0;
            mul2_q <= 1'b0;
        end else if (clear) begin
            a_q    <= '0;
            b_q    <= '0;
            pp_lo  <= '0;
            pp_hi  <= '0;
            mul1_q <= 1'b0;
            mul2_q <= 1'b0;
        end else begin
            mul1_q <= start;
            mul2_q <= mul1_q;
            if (start) begin
                a_q <= a;
                b_q <= b;
            end
            if (mul1_q) begin
                // A*B[lo] keeps all low bits; A[lo]*B[hi] only
                // contributes to the upper half after the shift.
                pp_lo <= a_q * {{H{1'b0}}, b_q[H-1:0]};
                pp_hi <= a_q[H-1:0] * b_q[DATA_W-1:H];
            end
        end
    end

    assign product = pp_lo + {pp_hi, {H{1'b0}}};
    assign busy    = mul1_q;
    assign done    = mul2_q;

endmodule

// File: rtl/ex_stage_mult2.sv
// Execute stage: combinational ALU plus two-step MUL with stall/bubble.
// Ports: clk, arst_n, bus (slave side of ex_stage_mult2_if).
module ex_stage_mult2 #(
    parameter int DATA_W = ex_pkg::DATA_W_DEF,
    parameter int PC_W   = ex_pkg::PC_W_DEF
) (
    input logic              clk,
    input logic              arst_n,
    ex_stage_mult2_if.slave  bus
);

    import ex_pkg::*;

    state_e            state;
    alu_op_e           op;
    ctrl_t             ctrl_in;
    ctrl_t             ctrl_q;
    ctrl_t             ctrl_out;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] product;
    logic              mul_busy;
    logic              mul_done;
    logic              is_mul;
    logic              issue;
    logic              bubble;
    logic              in_mul2;

    logic [4:0]        rd_q;
    logic [DATA_W-1:0] d2_q;
    logic [PC_W-1:0]   pc_q;
    logic [DATA_W-1:0] imm_q;
    logic [PC_W-1:0]   sel_pc;
    logic [DATA_W-1:0] sel_imm;

    assign op      = alu_op_e'(bus.alu_op);
    assign is_mul  = (op == OP_MUL);
    assign issue   = (state == IDLE) && is_mul && !bus.flush;
    assign bubble  = ((state == IDLE) && is_mul) || (state == MUL1);
    assign in_mul2 = (state == MUL2);
    assign opb     = bus.alu_src ? bus.imm : bus.rdata2;

    assign ctrl_in = '{
        regwrite: bus.regwrite_in,
        memtoreg: bus.memtoreg_in,
        memwrite: bus.memwrite_in,
        memread:  bus.memread_in,
        branch:   bus.branch_in
    };

    always_comb begin
        alu_res = bus.rdata1 + opb;
        case (op)
            OP_SUB: alu_res = bus.rdata1 - opb;
            OP_AND: alu_res = bus.rdata1 & opb;
            OP_OR:  alu_res = bus.rdata1 | opb;
            OP_SLT: alu_res = {{(DATA_W-1){1'b0}},
                               $signed(bus.rdata1) < $signed(opb)};
            default: alu_res = bus.rdata1 + opb;
        endcase
    end

    mult2_core #(.DATA_W(DATA_W)) u_core (
        .clk     (clk),
        .arst_n  (arst_n),
        .start   (issue),
        .clear   (bus.flush),
        .a       (bus.rdata1),
        .b       (opb),
        .product (product),
        .busy    (mul_busy),
        .done    (mul_done)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else if (bus.flush) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    state <= is_mul ? MUL1 : IDLE;
                MUL1:    state <= MUL2;
                MUL2:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_q   <= '0;
            d2_q   <= '0;
            pc_q   <= '0;
            imm_q  <= '0;
            ctrl_q <= '0;
        end else if (bus.flush) begin
            rd_q   <= '0;
            d2_q   <= '0;
            pc_q   <= '0;
            imm_q  <= '0;
            ctrl_q <= '0;
        end else if (issue) begin
            rd_q   <= bus.rd_in;
            d2_q   <= bus.rdata2;
            pc_q   <= bus.pc_in;
            imm_q  <= bus.imm;
            ctrl_q <= ctrl_in;
        end
    end

    // Flush and the issue/MUL1 bubbles only zero the controls;
    // data fields may carry whatever the datapath holds.
    assign ctrl_out = (bus.flush || bubble) ? '0
                    : (in_mul2 ? ctrl_q : ctrl_in);

    assign sel_pc  = in_mul2 ? pc_q  : bus.pc_in;
    assign sel_imm = in_mul2 ? imm_q : bus.imm;

    assign bus.branch_pc  = sel_pc +
        ({{(PC_W-DATA_W){sel_imm[DATA_W-1]}}, sel_imm} << 1);
    assign bus.alu_out    = mul_done ? product : alu_res;
    assign bus.zero       = (bus.alu_out == '0);
    assign bus.dreg2      = in_mul2 ? d2_q : bus.rdata2;
    assign bus.inst2      = in_mul2 ? rd_q : bus.rd_in;
    assign bus.writeback1 = ctrl_out.regwrite;
    assign bus.writeback2 = ctrl_out.memtoreg;
    assign bus.memwrite   = ctrl_out.memwrite;
    assign bus.memread    = ctrl_out.memread;
    assign bus.membranch  = ctrl_out.branch;
    assign bus.stall      = issue || (mul_busy && !bus.flush);

endmodule

// File: tb/tb_ex_stage_mult2.sv
// Bench for ex_stage_mult2: directed steps then random instructions,
// checked against a plain-arithmetic reference of the execute stage.
module tb_ex_stage_mult2;

    import ex_pkg::*;

    logic clk    = 1'b0;
    logic arst_n = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    ex_stage_mult2_if bus ();

    ex_stage_mult2 dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    logic [4:0] obs_ctrl;
    assign obs_ctrl = {bus.writeback1, bus.writeback2, bus.memwrite,
                       bus.memread, bus.membranch};

    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        case (op)
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd5: begin
                p = 64'(a) * 64'(b);
                return p[31:0];
            end
            default: return a + b;
        endcase
    endfunction

    function automatic logic [63:0] bpc(input logic [63:0] pc,
                                        input logic [31:0] imm);
        longint s;
        s = longint'(signed'(imm));
        return pc + 64'(s * 2);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_instr(input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] imm,
                             input logic src, input logic [4:0] rd,
                             input logic [4:0] ctrl, input logic [63:0] pc,
                             input logic fl);
        bus.alu_op      = op;
        bus.rdata1      = a;
        bus.rdata2      = b;
        bus.imm         = imm;
        bus.alu_src     = src;
        bus.rd_in       = rd;
        bus.pc_in       = pc;
        bus.regwrite_in = ctrl[4];
        bus.memtoreg_in = ctrl[3];
        bus.memwrite_in = ctrl[2];
        bus.memread_in  = ctrl[1];
        bus.branch_in   = ctrl[0];
        bus.flush       = fl;
    endtask

    task automatic expect_out(input string tag, input logic e_stall,
                              input logic [4:0] e_ctrl, input bit data,
                              input logic [31:0] e_alu,
                              input logic [31:0] e_d2,
                              input logic [4:0] e_rd,
                              input logic [63:0] e_bpc);
        chk({tag, ".stall"}, 64'(bus.stall), 64'(e_stall));
        chk({tag, ".ctrl"}, 64'(obs_ctrl), 64'(e_ctrl));
        if (data) begin
            chk({tag, ".alu"}, 64'(bus.alu_out), 64'(e_alu));
            chk({tag, ".zero"}, 64'(bus.zero), 64'(e_alu == 32'd0));
            chk({tag, ".dreg2"}, 64'(bus.dreg2), 64'(e_d2));
            chk({tag, ".inst2"}, 64'(bus.inst2), 64'(e_rd));
            chk({tag, ".bpc"}, bus.branch_pc, e_bpc);
        end
    endtask

    task automatic run_alu(input string tag, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic src,
                           input logic [4:0] rd, input logic [4:0] ctrl,
                           input logic [63:0] pc, input logic fl);
        logic [31:0] e;
        set_instr(op, a, b, imm, src, rd, ctrl, pc, fl);
        @(negedge clk);
        e = model(op, a, src ? imm : b);
        expect_out(tag, 1'b0, fl ? 5'd0 : ctrl, !fl, e, b, rd, bpc(pc, imm));
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
    endtask

    // fl_at: cycle (0 issue, 1 MUL1, 2 MUL2) with flush; 3 = none
    task automatic run_mul(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm,
                           input logic src, input logic [4:0] rd,
                           input logic [4:0] ctrl, input logic [63:0] pc,
                           input int fl_at);
        logic [31:0] e;
        e = model(3'd5, a, src ? imm : b);
        set_instr(3'd5, a, b, imm, src, rd, ctrl, pc, 1'b0);
        for (int c = 0; c < 3; c++) begin
            bus.flush = (c == fl_at);
            @(negedge clk);
            if (c == fl_at) begin
                expect_out($sformatf("%s.fl%0d", tag, c), 1'b0, 5'd0,
                           1'b0, 32'd0, 32'd0, 5'd0, 64'd0);
                @(posedge clk);
                #1;
                break;
            end
            if (c < 2)
                expect_out($sformatf("%s.c%0d", tag, c), 1'b1, 5'd0,
                           1'b0, 32'd0, 32'd0, 5'd0, 64'd0);
            else
                expect_out($sformatf("%s.c%0d", tag, c), 1'b0, ctrl,
                           1'b1, e, b, rd, bpc(pc, imm));
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b0;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b, imm;
        logic [63:0] pc;
        logic        fl;

        set_instr(3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 64'd0, 1'b0);
        #2 arst_n = 1'b0;
        #1;
        expect_out("reset", 1'b0, 5'd0, 1'b1, 32'd0, 32'd0, 5'd0, 64'd0);
        chk("reset.state", 64'(dut.state), 64'(IDLE));
        chk("reset.pp_lo", 64'(dut.u_core.pp_lo), 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        run_alu("add", 3'd0, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3,
                5'b10000, 64'd0, 1'b0);
        run_alu("sub", 3'd1, 32'd9, 32'd9, 32'h10, 1'b0, 5'd4,
                5'b00001, 64'h100, 1'b0);
        run_alu("addi", 3'd0, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b1, 5'd5,
                5'b11000, 64'h8000, 1'b0);
        run_mul("mul", 32'h1234_5678, 32'h0001_0003, 32'd0, 1'b0, 5'd6,
                5'b10000, 64'h200, 3);
        run_mul("mulff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd7,
                5'b10000, 64'h204, 3);
        run_mul("mul34", 32'd3, 32'd4, 32'd0, 1'b0, 5'd8,
                5'b10000, 64'h208, 3);

        run_mul("mulfl", 32'd11, 32'd13, 32'd0, 1'b0, 5'd9,
                5'b10000, 64'h20C, 1);
        chk("flush.state", 64'(dut.state), 64'(IDLE));
        run_alu("addpf", 3'd0, 32'd100, 32'd23, 32'd0, 1'b0, 5'd10,
                5'b10000, 64'h210, 1'b0);

        set_instr(3'd5, 32'd21, 32'd2, 32'd0, 1'b0, 5'd11, 5'b10000,
                  64'h214, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        arst_n = 1'b0;
        set_instr(3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 64'd0, 1'b0);
        #1;
        expect_out("arst", 1'b0, 5'd0, 1'b1, 32'd0, 32'd0, 5'd0, 64'd0);
        chk("arst.state", 64'(dut.state), 64'(IDLE));
        chk("arst.pp_lo", 64'(dut.u_core.pp_lo), 64'd0);
        chk("arst.pp_hi", 64'(dut.u_core.pp_hi), 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        run_alu("slt", 3'd4, 32'hFFFF_FFFD, 32'd2, 32'd0, 1'b0, 5'd12,
                5'b10000, 64'h218, 1'b0);

        for (int i = 0; i < 300; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = (i % 5 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b   = (i % 7 == 0) ? a : $urandom;
            imm = (i % 3 == 0) ? 32'($signed(16'($urandom))) : $urandom;
            pc  = {$urandom, $urandom};
            fl  = ($urandom_range(0, 9) == 0);
            if (op == 3'd5)
                run_mul($sformatf("r%0d.mul", i), a, b, imm, 1'($urandom),
                        5'($urandom), 5'($urandom), pc,
                        fl ? int'($urandom_range(0, 2)) : 3);
            else
                run_alu($sformatf("r%0d.op%0d", i, op), op, a, b, imm,
                        1'($urandom), 5'($urandom), 5'($urandom), pc, fl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
